nios_dbg_ocimem_sequencer: RTL and testbench
============================================

Name: nios_dbg_ocimem_sequencer

Overview:
Sysclk-domain controller that turns the debug slave's take_action_ocimem_* pulses and jdo payload into single-word read/write transactions on the CPU's on-chip debug memory (OCI RAM). It returns results through MonDReg, monitor_ready and monitor_error. It sits between the debug slave wrapper and the OCI RAM port, one instance per processor. It owns address auto-increment, debug-mode write gating and access timeout.

Parameters:
ADDR_W, 8, OCI RAM word-address width (1..33)
TIMEOUT_CYCLES, 64, max cycles mem_req may wait for mem_ack before abort (>=2)
CNT_W, 7, timeout counter width; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
jdo  in  38  debug data from slave wrapper
take_action_ocimem_a  in  1  1-cycle pulse: load address, optional read
take_no_action_ocimem_a  in  1  1-cycle pulse: read at current address
take_action_ocimem_b  in  1  1-cycle pulse: write at current address
debugack  in  1  CPU is in debug mode
mem_req  out  1  access request, held until ack/abort
mem_we  out  1  1 = write, 0 = read; valid while mem_req
mem_addr  out  ADDR_W  word address
mem_wdata  out  32  write data
mem_ack  in  1  access complete; rdata valid same cycle for reads
mem_rdata  in  32  read data
MonDReg  out  32  last read data / echoed write data
monitor_ready  out  1  last command finished (ok or error)
monitor_error  out  1  last command failed
busy  out  1  FSM not IDLE

Behaviour:
- Async reset values: FSM=IDLE; addr=0; mem_req=0; mem_we=0; mem_wdata=0; MonDReg=0; monitor_ready=0; monitor_error=0; busy=0; timeout cnt=0.
- FSM states: IDLE, ACCESS, DONE.
- Same-cycle pulse priority: ocimem_a > ocimem_b > no_action_a. Lower-priority pulses are discarded silently.
- In IDLE, on a pulse at cycle N:
  - ocimem_a: addr <= jdo[ADDR_W+1:2]. If jdo[35]=1, start read; else no access, monitor_ready=1 and monitor_error=0 at N+1, stay IDLE.
  - no_action_a: start read at addr.
  - ocimem_b: if debugack=0, reject: monitor_error=1, monitor_ready=1 at N+1, no access. Otherwise start write, mem_wdata <= jdo[34:3].
- Starting an access: at N+1 mem_req=1 and mem_we set; monitor_ready=0, monitor_error=0, busy=1; state ACCESS; cnt=0.
- In ACCESS:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable.
  - cnt increments each cycle mem_ack=0.
  - mem_ack=1 at cycle M: MonDReg <= mem_rdata (read) or mem_wdata (write); addr <= addr+1, wrapping 2^ADDR_W-1 -> 0. At M+1: mem_req=0, state DONE, monitor_ready=1, monitor_error=0.
  - cnt reaching TIMEOUT_CYCLES-1 without ack: at next cycle mem_req=0, monitor_error=1, monitor_ready=1, addr unchanged, MonDReg unchanged, state DONE.
  - mem_ack in the same cycle as the timeout limit: ack wins.
- DONE lasts exactly 1 cycle, then IDLE. busy=0 in IDLE only.
- Any pulse arriving in ACCESS or DONE is dropped, no state change. monitor_error is not set by a drop.
- Minimum command-to-command spacing: 3 cycles after mem_ack.
- mem_addr always equals the addr register.
- Reset mid-access: mem_req drops immediately (asynchronous); the transaction is abandoned with no completion signalled.

Test Plan:
- Reset, then ocimem_a with jdo[35]=1 and jdo[ADDR_W+1:2]=8'h10, mem_ack 2 cycles after mem_req with rdata=32'hDEADBEEF -> mem_addr=0x10, mem_we=0, MonDReg=DEADBEEF, monitor_ready=1, monitor_error=0, addr becomes 0x11.
- debugack=1, ocimem_b with jdo[34:3]=32'h12345678 at addr 0x11, ack after 1 cycle -> mem_we=1, mem_wdata=12345678, MonDReg=12345678, addr becomes 0x12. Repeat with debugack=0 -> no mem_req, monitor_error=1, monitor_ready=1.
- addr=0xFF, no_action_a, ack -> read at 0xFF, addr wraps to 0x00.
- Read with mem_ack never asserted -> mem_req high for exactly 64 cycles then low, monitor_error=1, MonDReg and addr unchanged. Variant with ack on the 64th cycle -> success.
- Pulse ocimem_b during ACCESS, and ocimem_a + ocimem_b in the same cycle from IDLE -> dropped pulse has no effect; ocimem_a alone executes.
- Assert reset_n=0 while mem_req=1 -> mem_req, busy and monitor_ready go 0 without waiting for a clock edge; after release the block accepts a fresh command normally.

Source files
------------

// File: rtl/nios_dbg_ocimem_sequencer_if.sv
// Bundle of the command side (debug slave wrapper) and the OCI RAM port
// of the OCI memory sequencer.
//   jdo, take_*_ocimem_*, debugack : commands and payload from the debug slave
//   mem_req/we/addr/wdata          : single-word access request to the OCI RAM
//   mem_ack/rdata                  : completion and read data from the OCI RAM
//   MonDReg, monitor_*, busy       : result and status back to the debug slave
// Modport slave is the sequencer; modport master is its environment.
interface nios_dbg_ocimem_sequencer_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [37:0]       jdo;
  logic              take_action_ocimem_a;
  logic              take_no_action_ocimem_a;
  logic              take_action_ocimem_b;
  logic              debugack;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic [31:0]       MonDReg;
  logic              monitor_ready;
  logic              monitor_error;
  logic              busy;

  modport master (
    output jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
    output debugack, mem_ack, mem_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, MonDReg, monitor_ready, monitor_error, busy
  );

  modport slave (
    input  jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
    input  debugack, mem_ack, mem_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, MonDReg, monitor_ready, monitor_error, busy
  );
endinterface

// File: rtl/nios_dbg_ocimem_sequencer.sv
// Sysclk-domain OCI RAM sequencer: turns take_action_ocimem_* pulses into
// single-word reads/writes, auto-increments the word address after each
// successful access, gates writes on debug mode and aborts accesses that are
// not acknowledged within TIMEOUT_CYCLES.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : command, OCI RAM and status signals (slave modport)
module nios_dbg_ocimem_sequencer #(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input logic                             clk,
  input logic                             reset_n,
  nios_dbg_ocimem_sequencer_if.slave      bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e            r_state, w_state_d;
  logic [ADDR_W-1:0] r_addr, w_addr_d;
  logic              r_req, w_req_d;
  logic              r_we, w_we_d;
  logic [31:0]       r_wdata, w_wdata_d;
  logic [31:0]       r_dreg, w_dreg_d;
  logic              r_ready, w_ready_d;
  logic              r_error, w_error_d;
  logic [CNT_W-1:0]  r_cnt, w_cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_addr  <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_dreg  <= '0;
      r_ready <= 1'b0;
      r_error <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_addr  <= w_addr_d;
      r_req   <= w_req_d;
      r_we    <= w_we_d;
      r_wdata <= w_wdata_d;
      r_dreg  <= w_dreg_d;
      r_ready <= w_ready_d;
      r_error <= w_error_d;
      r_cnt   <= w_cnt_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_addr_d  = r_addr;
    w_req_d   = r_req;
    w_we_d    = r_we;
    w_wdata_d = r_wdata;
    w_dreg_d  = r_dreg;
    w_ready_d = r_ready;
    w_error_d = r_error;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StIdle: begin
        // Priority a > b > no_action_a; losing pulses are simply ignored.
        if (bus.take_action_ocimem_a) begin
          w_addr_d = bus.jdo[ADDR_W+1:2];
          if (bus.jdo[35]) begin
            w_state_d = StAccess;
            w_req_d   = 1'b1;
            w_we_d    = 1'b0;
            w_ready_d = 1'b0;
            w_error_d = 1'b0;
            w_cnt_d   = '0;
          end else begin
            w_ready_d = 1'b1;
            w_error_d = 1'b0;
          end
        end else if (bus.take_action_ocimem_b) begin
          if (!bus.debugack) begin
            // Writes outside debug mode are refused without touching the RAM.
            w_ready_d = 1'b1;
            w_error_d = 1'b1;
          end else begin
            w_state_d = StAccess;
            w_req_d   = 1'b1;
            w_we_d    = 1'b1;
            w_wdata_d = bus.jdo[34:3];
            w_ready_d = 1'b0;
            w_error_d = 1'b0;
            w_cnt_d   = '0;
          end
        end else if (bus.take_no_action_ocimem_a) begin
          w_state_d = StAccess;
          w_req_d   = 1'b1;
          w_we_d    = 1'b0;
          w_ready_d = 1'b0;
          w_error_d = 1'b0;
          w_cnt_d   = '0;
        end
      end
      StAccess: begin
        // An ack coinciding with the timeout limit still completes the access.
        if (bus.mem_ack) begin
          w_dreg_d  = r_we ? r_wdata : bus.mem_rdata;
          w_addr_d  = r_addr + ADDR_W'(1);
          w_req_d   = 1'b0;
          w_ready_d = 1'b1;
          w_error_d = 1'b0;
          w_state_d = StDone;
        end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_req_d   = 1'b0;
          w_ready_d = 1'b1;
          w_error_d = 1'b1;
          w_state_d = StDone;
        end else begin
          w_cnt_d = r_cnt + CNT_W'(1);
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  assign bus.mem_req       = r_req;
  assign bus.mem_we        = r_we;
  assign bus.mem_addr      = r_addr;
  assign bus.mem_wdata     = r_wdata;
  assign bus.MonDReg       = r_dreg;
  assign bus.monitor_ready = r_ready;
  assign bus.monitor_error = r_error;
  assign bus.busy          = (r_state != StIdle);

endmodule

// File: tb/tb_nios_dbg_ocimem_sequencer.sv
// Self-checking bench for nios_dbg_ocimem_sequencer: directed scenarios
// followed by randomized commands, checked against a transaction-level model
// of the address register, MonDReg and the monitor status bits.
module tb_nios_dbg_ocimem_sequencer;
  localparam int unsigned AW = 8;
  localparam int unsigned TO = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  nios_dbg_ocimem_sequencer_if #(.ADDR_W(AW)) bus ();

  nios_dbg_ocimem_sequencer #(
    .ADDR_W         (AW),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (7)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state
  logic [AW-1:0] m_addr;
  logic [31:0]   m_dreg;
  logic          m_ready;
  logic          m_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_addr  = '0;
    m_dreg  = '0;
    m_ready = 1'b0;
    m_err   = 1'b0;
  endtask

  // kind: 0 = ocimem_a, 1 = ocimem_b, 2 = no_action_a.
  // lat: request cycle (0-based) on which mem_ack is given; >= TO means never.
  // extra: also pulse every lower-priority command in the same cycle.
  // inj: pulse ocimem_b (with fresh jdo) during the first access cycle.
  task automatic cmd(input int kind, input logic [AW-1:0] jaddr, input logic rd,
                     input logic [31:0] wd, input logic dbg, input int lat,
                     input logic [31:0] rdv, input logic extra, input logic inj);
    logic access;
    logic we;
    logic bad;
    int   req_cycles;
    int   exp_cycles;
    bus.debugack = dbg;
    case (kind)
      0:       bus.jdo = {2'($urandom), rd, 35'd0} | (38'(jaddr) << 2);
      1:       bus.jdo = {3'($urandom), wd, 3'($urandom)};
      default: bus.jdo = 38'($urandom);
    endcase
    bus.take_action_ocimem_a    = (kind == 0);
    bus.take_action_ocimem_b    = (kind == 1) || (kind == 0 && extra);
    bus.take_no_action_ocimem_a = (kind == 2) || (kind != 2 && extra);
    @(negedge clk);
    bus.take_action_ocimem_a    = 1'b0;
    bus.take_action_ocimem_b    = 1'b0;
    bus.take_no_action_ocimem_a = 1'b0;

    access = 1'b0;
    we     = 1'b0;
    case (kind)
      0: begin
        m_addr = jaddr;
        if (rd) access = 1'b1;
        else begin
          m_ready = 1'b1;
          m_err   = 1'b0;
        end
      end
      1: begin
        if (!dbg) begin
          m_ready = 1'b1;
          m_err   = 1'b1;
        end else begin
          access = 1'b1;
          we     = 1'b1;
        end
      end
      default: access = 1'b1;
    endcase

    if (!access) begin
      chk("noacc_req", bus.mem_req, 1'b0);
      chk("noacc_busy", bus.busy, 1'b0);
      chk("noacc_ready", bus.monitor_ready, m_ready);
      chk("noacc_error", bus.monitor_error, m_err);
      chk("noacc_addr", bus.mem_addr, m_addr);
      chk("noacc_dreg", bus.MonDReg, m_dreg);
      @(negedge clk);
      return;
    end

    chk("start_req", bus.mem_req, 1'b1);
    chk("start_we", bus.mem_we, we);
    chk("start_addr", bus.mem_addr, m_addr);
    chk("start_busy", bus.busy, 1'b1);
    chk("start_ready", bus.monitor_ready, 1'b0);
    chk("start_error", bus.monitor_error, 1'b0);
    if (we) chk("start_wdata", bus.mem_wdata, wd);

    bad        = 1'b0;
    req_cycles = 0;
    for (int c = 0; c < int'(TO); c++) begin
      if (bus.mem_req === 1'b1) req_cycles++;
      if (bus.mem_addr !== m_addr || bus.mem_we !== we || (we && bus.mem_wdata !== wd))
        bad = 1'b1;
      if (inj && c == 0) begin
        bus.take_action_ocimem_b = 1'b1;
        bus.debugack             = 1'b1;
        bus.jdo                  = {6'($urandom), 32'($urandom)};
      end
      if (c == lat) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rdv;
      end
      @(negedge clk);
      bus.take_action_ocimem_b = 1'b0;
      bus.mem_ack              = 1'b0;
      if (c == lat) begin
        m_dreg  = we ? wd : rdv;
        m_addr  = m_addr + 1'b1;
        m_ready = 1'b1;
        m_err   = 1'b0;
        break;
      end
    end
    if (lat >= int'(TO)) begin
      m_ready = 1'b1;
      m_err   = 1'b1;
    end
    exp_cycles = (lat < int'(TO)) ? lat + 1 : int'(TO);
    chk("hold_stable", bad, 1'b0);
    chk("req_cycles", req_cycles, exp_cycles);
    chk("done_req", bus.mem_req, 1'b0);
    chk("done_dreg", bus.MonDReg, m_dreg);
    chk("done_addr", bus.mem_addr, m_addr);
    chk("done_ready", bus.monitor_ready, m_ready);
    chk("done_error", bus.monitor_error, m_err);
    chk("done_busy", bus.busy, 1'b1);
    @(negedge clk);
    chk("idle_busy", bus.busy, 1'b0);
    chk("idle_req", bus.mem_req, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    bus.jdo                     = '0;
    bus.take_action_ocimem_a    = 1'b0;
    bus.take_no_action_ocimem_a = 1'b0;
    bus.take_action_ocimem_b    = 1'b0;
    bus.debugack                = 1'b0;
    bus.mem_ack                 = 1'b0;
    bus.mem_rdata               = '0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req", bus.mem_req, 1'b0);
    chk("rst_we", bus.mem_we, 1'b0);
    chk("rst_addr", bus.mem_addr, '0);
    chk("rst_wdata", bus.mem_wdata, '0);
    chk("rst_dreg", bus.MonDReg, '0);
    chk("rst_ready", bus.monitor_ready, 1'b0);
    chk("rst_error", bus.monitor_error, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);

    // Load address 0x10 and read it
    cmd(0, 8'h10, 1'b1, '0, 1'b0, 2, 32'hDEADBEEF, 1'b0, 1'b0);
    // Write in debug mode, then refused write outside debug mode
    cmd(1, '0, 1'b0, 32'h12345678, 1'b1, 1, '0, 1'b0, 1'b0);
    cmd(1, '0, 1'b0, 32'hCAFEF00D, 1'b0, 1, '0, 1'b0, 1'b0);
    // Address wrap at 0xFF
    cmd(0, 8'hFF, 1'b0, '0, 1'b0, 0, '0, 1'b0, 1'b0);
    cmd(2, '0, 1'b0, '0, 1'b0, 0, 32'h0BADF00D, 1'b0, 1'b0);
    // Timeout, then ack on the last permitted cycle
    cmd(2, '0, 1'b0, '0, 1'b0, 1000, 32'h11111111, 1'b0, 1'b0);
    cmd(2, '0, 1'b0, '0, 1'b0, int'(TO) - 1, 32'h22222222, 1'b0, 1'b0);
    // Drop a pulse during ACCESS; simultaneous a+b+no_action from IDLE
    cmd(2, '0, 1'b0, '0, 1'b1, 3, 32'h33333333, 1'b0, 1'b1);
    cmd(0, 8'h40, 1'b1, '0, 1'b1, 1, 32'h44444444, 1'b1, 1'b0);
    cmd(1, '0, 1'b0, 32'h55555555, 1'b1, 2, '0, 1'b1, 1'b1);

    // Asynchronous reset while a request is outstanding
    bus.take_no_action_ocimem_a = 1'b1;
    @(negedge clk);
    bus.take_no_action_ocimem_a = 1'b0;
    chk("arst_pre_req", bus.mem_req, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("arst_req", bus.mem_req, 1'b0);
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_ready", bus.monitor_ready, 1'b0);
    chk("arst_addr", bus.mem_addr, m_addr);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    cmd(2, '0, 1'b0, '0, 1'b0, 1, 32'h66666666, 1'b0, 1'b0);

    // Randomized commands
    for (int i = 0; i < 40; i++) begin
      int k;
      int r;
      int lat;
      k   = $urandom_range(0, 2);
      r   = $urandom_range(0, 9);
      lat = (r < 7) ? r : ((r == 7) ? int'(TO) - 1 : ((r == 8) ? 500 : int'(TO) - 2));
      cmd(k, 8'($urandom), 1'($urandom), $urandom, 1'($urandom_range(0, 3) != 0), lat,
          $urandom, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
